// File: rtl/instr_encoder_if.sv
// Bus bundle for the instruction encoder: program-load control,
// the instruction field handshake, the memory write port and status.
interface instr_encoder_if;
    logic        start;
    logic [31:0] base_addr;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] count;

    modport master (
        output start, base_addr,
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
        output in_funct3, in_funct7, in_imm, in_last,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, base_addr,
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
        input  in_funct3, in_funct7, in_imm, in_last,
        output in_ready,
        output mem_we, mem_addr, mem_wdata, busy, done, err, count
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded RISC-V style instruction fields one
// at a time, packs them into 32-bit words and writes them to consecutive
// word addresses starting at base_addr. Immediates that cannot be encoded
// abort the program load with a sticky error flag.
module instr_encoder (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        ENCODE,
        WRITE,
        FINISH,
        FAIL
    } state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    state_t      state;
    state_t      nextState;

    logic [31:0] addr;
    logic [15:0] count;
    logic        err;
    logic [31:0] memAddr;
    logic [31:0] memWdata;

    logic [2:0]  fmtQ;
    logic [6:0]  opcodeQ;
    logic [4:0]  rdQ;
    logic [4:0]  rs1Q;
    logic [4:0]  rs2Q;
    logic [2:0]  funct3Q;
    logic [6:0]  funct7Q;
    logic [31:0] immQ;
    logic        lastQ;

    logic [31:0] word;
    logic        immOk;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    // An immediate fits an N-bit signed field when every bit above the
    // field's sign bit matches it (all zeros or all ones).
    assign fits12 = (&immQ[31:11]) | ~(|immQ[31:11]);
    assign fits13 = (&immQ[31:12]) | ~(|immQ[31:12]);
    assign fits21 = (&immQ[31:20]) | ~(|immQ[31:20]);

    // Pack the registered fields into an instruction word and decide whether
    // the immediate is representable for the selected format.
    always_comb begin
        word  = {25'd0, opcodeQ};
        immOk = 1'b0;
        case (fmtQ)
            FMT_R: begin
                word  = {funct7Q, rs2Q, rs1Q, funct3Q, rdQ, opcodeQ};
                immOk = 1'b1;
            end
            FMT_I: begin
                word  = {immQ[11:0], rs1Q, funct3Q, rdQ, opcodeQ};
                immOk = fits12;
            end
            FMT_S: begin
                word  = {immQ[11:5], rs2Q, rs1Q, funct3Q, immQ[4:0], opcodeQ};
                immOk = fits12;
            end
            FMT_B: begin
                word  = {immQ[12], immQ[10:5], rs2Q, rs1Q, funct3Q,
                         immQ[4:1], immQ[11], opcodeQ};
                immOk = fits13 & ~immQ[0];
            end
            FMT_U: begin
                word  = {immQ[31:12], rdQ, opcodeQ};
                immOk = ~(|immQ[11:0]);
            end
            FMT_J: begin
                word  = {immQ[20], immQ[10:1], immQ[11], immQ[19:12], rdQ, opcodeQ};
                immOk = fits21 & ~immQ[0];
            end
            default: begin
                word  = {25'd0, opcodeQ};
                immOk = 1'b0;
            end
        endcase
    end

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Sequencing: one instruction takes ACCEPT -> ENCODE -> WRITE, so the
    // write lands two cycles after its handshake.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start)    nextState = ACCEPT;
            ACCEPT:  if (bus.in_valid) nextState = ENCODE;
            ENCODE:  nextState = immOk ? WRITE : FAIL;
            WRITE:   nextState = lastQ ? FINISH : ACCEPT;
            FINISH:  nextState = IDLE;
            FAIL:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: capture fields on handshake, stage the write port during
    // ENCODE so it holds its value after the write, advance addr/count after
    // each write and latch the error flag on an aborted load.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr     <= '0;
            count    <= '0;
            err      <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            fmtQ     <= '0;
            opcodeQ  <= '0;
            rdQ      <= '0;
            rs1Q     <= '0;
            rs2Q     <= '0;
            funct3Q  <= '0;
            funct7Q  <= '0;
            immQ     <= '0;
            lastQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr  <= bus.base_addr;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (bus.in_valid) begin
                        fmtQ    <= bus.in_fmt;
                        opcodeQ <= bus.in_opcode;
                        rdQ     <= bus.in_rd;
                        rs1Q    <= bus.in_rs1;
                        rs2Q    <= bus.in_rs2;
                        funct3Q <= bus.in_funct3;
                        funct7Q <= bus.in_funct7;
                        immQ    <= bus.in_imm;
                        lastQ   <= bus.in_last;
                    end
                end
                ENCODE: begin
                    if (immOk) begin
                        memAddr  <= addr;
                        memWdata <= word;
                    end
                end
                WRITE: begin
                    addr  <= addr + 32'd4;
                    count <= count + 16'd1;
                end
                FAIL: begin
                    err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCEPT);
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FINISH);
    assign bus.err       = err;
    assign bus.count     = count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program loads plus
// randomized programs compared against an arithmetic reference encoder.
module tb_instr_encoder;

    logic clk;
    logic reset;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks;
    int          errors;
    logic [31:0] expAddr;
    logic [15:0] expCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // Reference encoder built from the field-placement rules with plain
    // integer arithmetic; legal reports whether the immediate is encodable.
    function automatic logic [31:0] refEncode(input int fmt, input longint op,
            input longint rd, input longint rs1, input longint rs2,
            input longint f3, input longint f7, input logic [31:0] imm,
            output bit legal);
        longint s;
        longint u;
        longint w;
        s = longint'($signed(imm));
        u = longint'(imm);
        legal = 1'b1;
        w = 0;
        case (fmt)
            0: w = f7 * (64'd1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7);
            1: begin
                legal = (s >= -2048) && (s <= 2047);
                w = (u % 4096) * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7);
            end
            2: begin
                legal = (s >= -2048) && (s <= 2047);
                w = ((u / 32) % 128) * (64'd1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                    + f3 * (1 << 12) + (u % 32) * (1 << 7);
            end
            3: begin
                legal = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
                w = ((u / 4096) % 2) * (64'd1 << 31) + ((u / 32) % 64) * (64'd1 << 25)
                    + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
                    + ((u / 2) % 16) * (1 << 8) + ((u / 2048) % 2) * (1 << 7);
            end
            4: begin
                legal = (u % 4096 == 0);
                w = (u / 4096) * (1 << 12) + rd * (1 << 7);
            end
            5: begin
                legal = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
                w = ((u / (1 << 20)) % 2) * (64'd1 << 31) + ((u / 2) % 1024) * (1 << 21)
                    + ((u / 2048) % 2) * (1 << 20) + ((u / 4096) % 256) * (1 << 12) + rd * (1 << 7);
            end
            default: legal = 1'b0;
        endcase
        w = w + op;
        return w[31:0];
    endfunction

    // Pick an immediate that is usually encodable for the format.
    function automatic logic [31:0] genImm(input int fmt);
        int v;
        v = 0;
        case (fmt)
            1, 2: v = int'($urandom_range(0, 4095)) - 2048;
            3:    v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            4:    v = int'($urandom & 32'hFFFFF000);
            5:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            default: v = int'($urandom);
        endcase
        if ($urandom_range(0, 5) == 0) begin
            v = ($urandom_range(0, 1) == 0) ? int'($urandom) : (v | 1);
        end
        return v;
    endfunction

    task automatic applyStimulus(input logic [31:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        step();
        bus.start     = 1'b0;
        expAddr       = base;
        expCount      = '0;
        checkOutput("start_ready", bus.in_ready, 1);
        checkOutput("start_err_clear", bus.err, 0);
        checkOutput("start_busy", bus.busy, 1);
    endtask

    // Present one instruction, follow it through the handshake, encode and
    // write/abort cycles and check every visible output along the way.
    task automatic sendInstr(input int fmt, input int op, input int rd,
            input int rs1, input int rs2, input int f3, input int f7,
            input logic [31:0] imm, input bit last, input bit useFixed,
            input logic [31:0] fixedWord, output bit ok);
        logic [31:0] expWord;
        expWord = refEncode(fmt, op, rd, rs1, rs2, f3, f7, imm, ok);
        if (useFixed) expWord = fixedWord;
        bus.in_fmt    = fmt[2:0];
        bus.in_opcode = op[6:0];
        bus.in_rd     = rd[4:0];
        bus.in_rs1    = rs1[4:0];
        bus.in_rs2    = rs2[4:0];
        bus.in_funct3 = f3[2:0];
        bus.in_funct7 = f7[6:0];
        bus.in_imm    = imm;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) break;
            step();
        end
        checkOutput("ready_wait", bus.in_ready, 1);
        step();
        // Encode cycle: garbage on the inputs must not disturb the result.
        bus.in_valid  = 1'b0;
        bus.in_fmt    = 3'($urandom);
        bus.in_opcode = 7'($urandom);
        bus.in_rd     = 5'($urandom);
        bus.in_rs1    = 5'($urandom);
        bus.in_rs2    = 5'($urandom);
        bus.in_imm    = $urandom;
        bus.in_last   = 1'($urandom);
        checkOutput("encode_we", bus.mem_we, 0);
        checkOutput("encode_ready", bus.in_ready, 0);
        step();
        if (ok) begin
            checkOutput("write_we", bus.mem_we, 1);
            checkOutput("write_addr", bus.mem_addr, expAddr);
            checkOutput("write_data", bus.mem_wdata, expWord);
            step();
            checkOutput("post_we", bus.mem_we, 0);
            checkOutput("post_addr_hold", bus.mem_addr, expAddr);
            checkOutput("post_data_hold", bus.mem_wdata, expWord);
            expAddr  = expAddr + 32'd4;
            expCount = expCount + 16'd1;
            checkOutput("post_count", bus.count, expCount);
            if (last) begin
                checkOutput("finish_done", bus.done, 1);
                step();
                checkOutput("idle_done", bus.done, 0);
                checkOutput("idle_busy", bus.busy, 0);
                checkOutput("idle_count", bus.count, expCount);
            end else begin
                checkOutput("next_ready", bus.in_ready, 1);
                checkOutput("next_done", bus.done, 0);
            end
        end else begin
            checkOutput("fail_we", bus.mem_we, 0);
            checkOutput("fail_done", bus.done, 0);
            step();
            checkOutput("abort_err", bus.err, 1);
            checkOutput("abort_busy", bus.busy, 0);
            checkOutput("abort_we", bus.mem_we, 0);
            checkOutput("abort_count", bus.count, expCount);
            step();
            checkOutput("abort_err_held", bus.err, 1);
        end
    endtask

    initial begin
        bit ok;
        int n;
        int fmt;
        checks        = 0;
        errors        = 0;
        expAddr       = '0;
        expCount      = '0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.in_valid  = 1'b0;
        bus.in_fmt    = '0;
        bus.in_opcode = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_imm    = '0;
        bus.in_last   = 1'b0;
        reset         = 1'b1;
        step();
        step();
        checkOutput("rst_we", bus.mem_we, 0);
        checkOutput("rst_ready", bus.in_ready, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_err", bus.err, 0);
        checkOutput("rst_count", bus.count, 0);
        checkOutput("rst_addr", bus.mem_addr, 0);
        checkOutput("rst_data", bus.mem_wdata, 0);
        reset = 1'b0;
        step();

        $display("[TB] single I-type word");
        applyStimulus(32'h100);
        sendInstr(1, 7'b0010011, 1, 0, 0, 0, 0, 32'd5, 1'b1, 1'b1, 32'h00500093, ok);

        $display("[TB] S and B words, then three-word program");
        applyStimulus(32'h100);
        sendInstr(2, 7'b0100011, 0, 3, 2, 3'b010, 0, 32'd8, 1'b0, 1'b1, 32'h0021A423, ok);
        sendInstr(3, 7'b1100011, 0, 0, 0, 0, 0, -32'sd4, 1'b0, 1'b1, 32'hFE000EE3, ok);
        sendInstr(0, 7'b0110011, 5, 6, 7, 0, 7'h20, 32'd0, 1'b1, 1'b0, 32'd0, ok);
        checkOutput("three_count", bus.count, 3);

        $display("[TB] encoding failures");
        applyStimulus(32'h100);
        sendInstr(1, 7'b0010011, 1, 0, 0, 0, 0, 32'd5, 1'b0, 1'b0, 32'd0, ok);
        sendInstr(3, 7'b1100011, 0, 0, 0, 0, 0, 32'd3, 1'b1, 1'b0, 32'd0, ok);
        applyStimulus(32'h100);
        sendInstr(1, 7'b0010011, 1, 0, 0, 0, 0, 32'd2048, 1'b1, 1'b0, 32'd0, ok);
        applyStimulus(32'h100);
        sendInstr(6, 7'b0010011, 1, 0, 0, 0, 0, 32'd0, 1'b1, 1'b0, 32'd0, ok);

        $display("[TB] start ignored while accepting");
        applyStimulus(32'h200);
        bus.start     = 1'b1;
        bus.base_addr = 32'h900;
        step();
        bus.start     = 1'b0;
        checkOutput("restart_ready", bus.in_ready, 1);
        sendInstr(4, 7'b0110111, 9, 0, 0, 0, 0, 32'hABCDE000, 1'b1, 1'b0, 32'd0, ok);

        $display("[TB] reset during write");
        applyStimulus(32'h300);
        bus.in_fmt    = 3'd1;
        bus.in_opcode = 7'b0010011;
        bus.in_imm    = 32'd1;
        bus.in_last   = 1'b1;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        step();
        checkOutput("rw_we_before", bus.mem_we, 1);
        reset = 1'b1;
        step();
        checkOutput("rw_we", bus.mem_we, 0);
        checkOutput("rw_busy", bus.busy, 0);
        checkOutput("rw_count", bus.count, 0);
        checkOutput("rw_addr", bus.mem_addr, 0);
        checkOutput("rw_data", bus.mem_wdata, 0);
        bus.start = 1'b1;
        step();
        checkOutput("rst_over_start", bus.busy, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        step();
        checkOutput("rw_idle", bus.busy, 0);

        $display("[TB] randomized programs");
        for (int p = 0; p < 30; p++) begin
            applyStimulus($urandom & 32'hFFFFFFFC);
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                fmt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7))
                                                  : int'($urandom_range(0, 5));
                sendInstr(fmt, int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                          genImm(fmt), (k == n - 1), 1'b0, 32'd0, ok);
                if (!ok) break;
            end
        end

        $display("[TB] address wrap");
        applyStimulus(32'hFFFFFFFC);
        sendInstr(0, 7'h33, 1, 2, 3, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, ok);
        sendInstr(0, 7'h33, 4, 5, 6, 0, 0, 32'd0, 1'b1, 1'b0, 32'd0, ok);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
